// File: rtl/hex_display_scanner.sv
// hex_display_scanner: time-multiplexed seven-segment hex driver with
// frame-synchronous value updates and optional leading-zero blanking.
module hex_display_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    enable,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_start,
  output logic                    update_pending
);

  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PCNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [IDX_W-1:0]      IDX_MAX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PCNT_W-1:0]     PCNT_MAX = PCNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0]            SEG_OFF  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] SEL_OFF  = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [PCNT_W-1:0]       pcnt_reg, pcnt_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [4*NUM_DIGITS-1:0] shadow_reg, shadow_next;
  logic [4*NUM_DIGITS-1:0] pending_reg, pending_next;
  logic                    pend_v_reg, pend_v_next;
  logic                    wrapped_reg, wrapped_next;
  logic [6:0]              seg_reg, seg_next;
  logic [NUM_DIGITS-1:0]   digit_sel_reg, digit_sel_next;
  logic                    frame_start_reg, frame_start_next;

  logic                    tick, boundary;
  logic [NUM_DIGITS-1:0]   sel_on;
  logic [3:0]              cur_nib;
  logic                    cur_blank, all_zero;
  logic [6:0]              seg_al;
  logic [NUM_DIGITS-1:0]   sel_hi;

  // Active-low glyph patterns, seg[6:0] = g..a.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    glyph = 7'h7F;
    case (n)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      4'hF: glyph = 7'b0001110;
      default: glyph = 7'h7F;
    endcase
  endfunction

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_sel
    assign sel_on[gi] = (idx_reg == IDX_W'(gi));
  end

  // Scan from the top digit down so all_zero covers nibbles i..NUM_DIGITS-1.
  always_comb begin
    cur_nib   = 4'h0;
    cur_blank = 1'b0;
    all_zero  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero && (shadow_reg[4*i +: 4] == 4'h0);
      if (sel_on[i]) begin
        cur_nib   = shadow_reg[4*i +: 4];
        cur_blank = blank_lz && all_zero && (i != 0);
      end
    end
  end

  always_comb begin
    tick         = enable && (pcnt_reg == PCNT_MAX);
    boundary     = tick && (idx_reg == IDX_MAX);
    pcnt_next    = pcnt_reg;
    idx_next     = idx_reg;
    shadow_next  = shadow_reg;
    pending_next = pending_reg;
    pend_v_next  = pend_v_reg;
    wrapped_next = wrapped_reg;
    if (enable) begin
      pcnt_next = tick ? '0 : pcnt_reg + 1'b1;
      if (tick)
        idx_next = (idx_reg == IDX_MAX) ? '0 : idx_reg + 1'b1;
      wrapped_next = boundary;
      // A load on the boundary cycle skips the pending stage entirely.
      if (load && boundary) begin
        shadow_next = value;
        pend_v_next = 1'b0;
      end else if (load) begin
        pending_next = value;
        pend_v_next  = 1'b1;
      end else if (boundary && pend_v_reg) begin
        shadow_next = pending_reg;
        pend_v_next = 1'b0;
      end
    end else if (load) begin
      shadow_next = value;
      pend_v_next = 1'b0;
    end
  end

  always_comb begin
    seg_al = 7'h7F;
    sel_hi = '0;
    if (enable) begin
      sel_hi = sel_on;
      if (!cur_blank)
        seg_al = glyph(cur_nib);
    end
    seg_next         = (ACTIVE_LOW != 0) ? seg_al : ~seg_al;
    digit_sel_next   = (ACTIVE_LOW != 0) ? ~sel_hi : sel_hi;
    frame_start_next = enable && wrapped_reg;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pcnt_reg        <= '0;
      idx_reg         <= '0;
      shadow_reg      <= '0;
      pending_reg     <= '0;
      pend_v_reg      <= 1'b0;
      wrapped_reg     <= 1'b0;
      seg_reg         <= SEG_OFF;
      digit_sel_reg   <= SEL_OFF;
      frame_start_reg <= 1'b0;
    end else begin
      pcnt_reg        <= pcnt_next;
      idx_reg         <= idx_next;
      shadow_reg      <= shadow_next;
      pending_reg     <= pending_next;
      pend_v_reg      <= pend_v_next;
      wrapped_reg     <= wrapped_next;
      seg_reg         <= seg_next;
      digit_sel_reg   <= digit_sel_next;
      frame_start_reg <= frame_start_next;
    end
  end

  assign seg            = seg_reg;
  assign digit_sel      = digit_sel_reg;
  assign frame_start    = frame_start_reg;
  assign update_pending = pend_v_reg;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner: a frame-position reference model predicts
// every registered output under randomized load/enable/blanking stimulus.
module tb_hex_display_scanner;

  localparam int N  = 4;
  localparam int RD = 3;
  localparam int F  = N * RD;

  logic        clock = 1'b0;
  logic        reset, load, enable, blank_lz;
  logic [15:0] value;
  logic [6:0]  seg;
  logic [3:0]  digit_sel;
  logic        frame_start, update_pending;

  logic [3:0]  value1;
  logic        load1, enable1, blank1;
  logic [6:0]  seg1;
  logic [0:0]  digit_sel1;
  logic        fs1, up1;

  int n_checks = 0;
  int n_passed = 0;

  // Model state: scan position is derived from enabled cycles since reset.
  int          m_ecount;
  logic [15:0] m_shadow, m_pend;
  bit          m_pend_v;
  logic [6:0]  exp_seg;
  logic [3:0]  exp_sel;
  logic        exp_fs, exp_up;

  logic [6:0] glyph_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  always #5 clock = ~clock;

  hex_display_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .ACTIVE_LOW(1)) dut (
    .clock(clock), .reset(reset), .value(value), .load(load), .enable(enable),
    .blank_lz(blank_lz), .seg(seg), .digit_sel(digit_sel),
    .frame_start(frame_start), .update_pending(update_pending));

  hex_display_scanner #(.NUM_DIGITS(1), .REFRESH_DIV(1), .ACTIVE_LOW(1)) dut1 (
    .clock(clock), .reset(reset), .value(value1), .load(load1), .enable(enable1),
    .blank_lz(blank1), .seg(seg1), .digit_sel(digit_sel1),
    .frame_start(fs1), .update_pending(up1));

  // Predict the outputs of the coming edge, advance the model, then clock.
  task automatic step();
    int pos, d;
    bit boundary, blank;
    logic [3:0] onehot;
    pos = m_ecount % F;
    d   = pos / RD;
    if (reset || !enable) begin
      exp_seg = 7'h7F; exp_sel = 4'hF; exp_fs = 1'b0;
    end else begin
      blank   = blank_lz && (d != 0) && ((m_shadow >> (4*d)) == 16'h0);
      exp_seg = blank ? 7'h7F : glyph_tab[m_shadow[4*d +: 4]];
      onehot  = 4'b0001 << d;
      exp_sel = ~onehot;
      exp_fs  = (pos == 0) && (m_ecount > 0);
    end
    if (reset) begin
      m_ecount = 0; m_shadow = 16'h0; m_pend_v = 1'b0;
    end else if (enable) begin
      boundary = (pos == F - 1);
      if (load && boundary) begin m_shadow = value; m_pend_v = 1'b0; end
      else if (load) begin m_pend = value; m_pend_v = 1'b1; end
      else if (boundary && m_pend_v) begin m_shadow = m_pend; m_pend_v = 1'b0; end
      m_ecount++;
    end else if (load) begin
      m_shadow = value; m_pend_v = 1'b0;
    end
    exp_up = m_pend_v;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; enable = 1'b0; blank_lz = 1'b0; value = 16'h0;
    step(); step();
    n_checks++; if (seg !== 7'h7F) $display("FAIL reset_seg got %b want %b", seg, 7'h7F); else n_passed++;
    n_checks++; if (digit_sel !== 4'hF) $display("FAIL reset_sel got %b want %b", digit_sel, 4'hF); else n_passed++;
    n_checks++; if (frame_start !== 1'b0) $display("FAIL reset_fs got %b want 0", frame_start); else n_passed++;
    n_checks++; if (update_pending !== 1'b0) $display("FAIL reset_up got %b want 0", update_pending); else n_passed++;
    reset = 1'b0; enable = 1'b1;
    step();
    n_checks++; if (digit_sel !== 4'b1110) $display("FAIL first_sel got %b want 1110", digit_sel); else n_passed++;
    n_checks++; if (seg !== 7'b1000000) $display("FAIL first_seg got %b want 1000000", seg); else n_passed++;
    n_checks++; if (frame_start !== 1'b0) $display("FAIL first_fs got %b want 0", frame_start); else n_passed++;
  endtask

  task automatic test_basic_scan();
    value = 16'h12AF; load = 1'b1; blank_lz = 1'b0; enable = 1'b1;
    for (int i = 0; i < 2 * F + 2; i++) begin
      step();
      load = 1'b0;
      n_checks++; if (seg !== exp_seg) $display("FAIL scan_seg t=%0t got %b want %b", $time, seg, exp_seg); else n_passed++;
      n_checks++; if (digit_sel !== exp_sel) $display("FAIL scan_sel t=%0t got %b want %b", $time, digit_sel, exp_sel); else n_passed++;
      n_checks++; if (frame_start !== exp_fs) $display("FAIL scan_fs t=%0t got %b want %b", $time, frame_start, exp_fs); else n_passed++;
      n_checks++; if (update_pending !== exp_up) $display("FAIL scan_up t=%0t got %b want %b", $time, update_pending, exp_up); else n_passed++;
    end
  endtask

  task automatic test_frame_update();
    enable = 1'b0; load = 1'b1; value = 16'h0000;
    step();
    load = 1'b0; enable = 1'b1;
    for (int k = 0; k < 2 * F && (m_ecount % F) != 5; k++) step();
    value = 16'h1234; load = 1'b1;
    for (int i = 0; i < 2 * F; i++) begin
      step();
      load = 1'b0;
      n_checks++; if (seg !== exp_seg) $display("FAIL upd_seg t=%0t got %b want %b", $time, seg, exp_seg); else n_passed++;
      n_checks++; if (digit_sel !== exp_sel) $display("FAIL upd_sel t=%0t got %b want %b", $time, digit_sel, exp_sel); else n_passed++;
      n_checks++; if (frame_start !== exp_fs) $display("FAIL upd_fs t=%0t got %b want %b", $time, frame_start, exp_fs); else n_passed++;
      n_checks++; if (update_pending !== exp_up) $display("FAIL upd_up t=%0t got %b want %b", $time, update_pending, exp_up); else n_passed++;
    end
  endtask

  task automatic test_bypass_overwrite();
    enable = 1'b1;
    value = 16'h1111; load = 1'b1; step();
    load = 1'b0; step();
    value = 16'h2222; load = 1'b1; step();
    load = 1'b0;
    for (int k = 0; k < 2 * F && (m_ecount % F) != F - 1; k++) step();
    step();
    for (int k = 0; k < 2 * F && (m_ecount % F) != F - 1; k++) step();
    value = 16'h3333; load = 1'b1;
    for (int i = 0; i < F + 2; i++) begin
      step();
      load = 1'b0;
      n_checks++; if (seg !== exp_seg) $display("FAIL byp_seg t=%0t got %b want %b", $time, seg, exp_seg); else n_passed++;
      n_checks++; if (digit_sel !== exp_sel) $display("FAIL byp_sel t=%0t got %b want %b", $time, digit_sel, exp_sel); else n_passed++;
      n_checks++; if (frame_start !== exp_fs) $display("FAIL byp_fs t=%0t got %b want %b", $time, frame_start, exp_fs); else n_passed++;
      n_checks++; if (update_pending !== 1'b0) $display("FAIL byp_up t=%0t got %b want 0", $time, update_pending); else n_passed++;
    end
  endtask

  task automatic test_leading_zeros();
    logic [31:0] r;
    blank_lz = 1'b1; enable = 1'b0; load = 1'b1; value = 16'h00F0;
    for (int j = 0; j < 8; j++) begin
      step();
      load = 1'b0; enable = 1'b1;
      for (int i = 0; i < 2 * F + 1; i++) begin
        step();
        n_checks++; if (seg !== exp_seg) $display("FAIL lz_seg t=%0t got %b want %b", $time, seg, exp_seg); else n_passed++;
        n_checks++; if (digit_sel !== exp_sel) $display("FAIL lz_sel t=%0t got %b want %b", $time, digit_sel, exp_sel); else n_passed++;
      end
      r = $urandom;
      value = r[15:0] >> (4 * $urandom_range(0, 4));
      blank_lz = (j < 5) ? 1'b1 : 1'($urandom_range(0, 1));
      enable = 1'($urandom_range(0, 1));
      load = 1'b1;
    end
  endtask

  task automatic test_enable_reset();
    logic [31:0] r;
    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      value = r[15:0];
      enable = ($urandom_range(0, 3) != 0);
      load = ($urandom_range(0, 7) == 0);
      blank_lz = 1'($urandom_range(0, 1));
      step();
      n_checks++; if (seg !== exp_seg) $display("FAIL rnd_seg t=%0t got %b want %b", $time, seg, exp_seg); else n_passed++;
      n_checks++; if (digit_sel !== exp_sel) $display("FAIL rnd_sel t=%0t got %b want %b", $time, digit_sel, exp_sel); else n_passed++;
      n_checks++; if (frame_start !== exp_fs) $display("FAIL rnd_fs t=%0t got %b want %b", $time, frame_start, exp_fs); else n_passed++;
      n_checks++; if (update_pending !== exp_up) $display("FAIL rnd_up t=%0t got %b want %b", $time, update_pending, exp_up); else n_passed++;
    end
    enable = 1'b1; blank_lz = 1'b0; load = 1'b0;
    for (int k = 0; k < 2 * F && (m_ecount % F) != 4; k++) step();
    value = 16'hBEEF; load = 1'b1; step();
    reset = 1'b1; load = 1'b1; step();
    n_checks++; if (seg !== 7'h7F) $display("FAIL rst_seg got %b want %b", seg, 7'h7F); else n_passed++;
    n_checks++; if (digit_sel !== 4'hF) $display("FAIL rst_sel got %b want 1111", digit_sel); else n_passed++;
    n_checks++; if (update_pending !== 1'b0) $display("FAIL rst_up got %b want 0", update_pending); else n_passed++;
    reset = 1'b0; load = 1'b0; step();
    n_checks++; if (digit_sel !== 4'b1110) $display("FAIL post_rst_sel got %b want 1110", digit_sel); else n_passed++;
    n_checks++; if (seg !== 7'b1000000) $display("FAIL post_rst_seg got %b want 1000000", seg); else n_passed++;
    n_checks++; if (update_pending !== 1'b0) $display("FAIL post_rst_up got %b want 0", update_pending); else n_passed++;
  endtask

  task automatic test_single_digit();
    logic [3:0] v;
    enable1 = 1'b1; blank1 = 1'b0; load1 = 1'b0;
    reset = 1'b1; step();
    reset = 1'b0; step();
    n_checks++; if (fs1 !== 1'b0) $display("FAIL sd_first_fs got %b want 0", fs1); else n_passed++;
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++; if (fs1 !== 1'b1) $display("FAIL sd_fs got %b want 1", fs1); else n_passed++;
      n_checks++; if (digit_sel1 !== 1'b0) $display("FAIL sd_sel got %b want 0", digit_sel1); else n_passed++;
    end
    for (int i = 0; i < 5; i++) begin
      v = 4'($urandom_range(0, 15));
      value1 = v; load1 = 1'b1; step();
      load1 = 1'b0; step();
      n_checks++; if (seg1 !== glyph_tab[v]) $display("FAIL sd_seg got %b want %b", seg1, glyph_tab[v]); else n_passed++;
      n_checks++; if (up1 !== 1'b0) $display("FAIL sd_up got %b want 0", up1); else n_passed++;
    end
  endtask

  initial begin
    value1 = 4'h0; load1 = 1'b0; enable1 = 1'b0; blank1 = 1'b0;
    m_ecount = 0; m_shadow = 16'h0; m_pend = 16'h0; m_pend_v = 1'b0;
    test_reset();
    test_basic_scan();
    test_frame_update();
    test_bypass_overwrite();
    test_leading_zeros();
    test_enable_reset();
    test_single_digit();
    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
